// File: rtl/cpu_defs_pkg.sv
// Shared CPU definitions: control FSM state codes, opcode values and the
// packed control word used by the multicycle controller.
package cpu_defs_pkg;

    // Controller state codes (4-bit encoding, codes 12-15 unused)
    localparam logic [3:0] S_FETCH  = 4'd0;
    localparam logic [3:0] S_DECODE = 4'd1;
    localparam logic [3:0] S_MEMADR = 4'd2;
    localparam logic [3:0] S_MEMRD  = 4'd3;
    localparam logic [3:0] S_MEMWB  = 4'd4;
    localparam logic [3:0] S_MEMWR  = 4'd5;
    localparam logic [3:0] S_EXEC   = 4'd6;
    localparam logic [3:0] S_RWB    = 4'd7;
    localparam logic [3:0] S_BRANCH = 4'd8;
    localparam logic [3:0] S_JUMP   = 4'd9;
    localparam logic [3:0] S_ADDIEX = 4'd10;
    localparam logic [3:0] S_ADDIWB = 4'd11;

    // Instruction opcodes (IR[31:26])
    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_ADDI = 6'b001000;

    // Next-PC select encodings
    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    // ALU operand B select encodings
    localparam logic [1:0] SRCB_REG  = 2'b00;
    localparam logic [1:0] SRCB_FOUR = 2'b01;
    localparam logic [1:0] SRCB_IMM  = 2'b10;
    localparam logic [1:0] SRCB_BOFS = 2'b11;

    // ALU operation classes
    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    // Complete set of datapath controls driven by the FSM
    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic [1:0] pc_source;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       mem_to_reg;
        logic       reg_dst;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
    } ctrl_t;

    // True when the opcode has a decode path out of DECODE
    function automatic logic op_is_legal(input logic [5:0] op, input logic addi_en);
        logic legal;
        legal = 1'b0;
        case (op)
            OP_R, OP_LW, OP_SW, OP_BEQ, OP_J: legal = 1'b1;
            OP_ADDI:                          legal = addi_en;
            default:                          legal = 1'b0;
        endcase
        return legal;
    endfunction

endpackage

// File: rtl/ctrl_fsm.sv
// Multicycle CPU main controller: Moore FSM sequencing fetch, decode,
// memory, ALU, branch and jump steps, with a sticky illegal-opcode flag.
module ctrl_fsm
    import cpu_defs_pkg::*;
#(
    parameter bit EN_ADDI = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] op,
    input  logic       mem_ready,
    output logic       PCWrite,
    output logic       PCWriteCond,
    output logic [1:0] PCSource,
    output logic       IorD,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       MemtoReg,
    output logic       RegDst,
    output logic       RegWrite,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ALUOp,
    output logic [3:0] state,
    output logic       ill_op
);

    logic [3:0] state_q, state_d;
    logic       ill_q, ill_d;
    ctrl_t      ctrl;

    // State and sticky flag registers; async active-low reset abandons any instruction
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_FETCH;
            ill_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ill_q   <= ill_d;
        end
    end

    // Next-state logic; memory states stall until mem_ready
    always_comb begin
        state_d = S_FETCH;
        ill_d   = ill_q;
        case (state_q)
            S_FETCH:  state_d = mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                if (!op_is_legal(op, EN_ADDI)) begin
                    state_d = S_FETCH;
                    ill_d   = 1'b1;
                end else begin
                    case (op)
                        OP_LW, OP_SW: state_d = S_MEMADR;
                        OP_R:         state_d = S_EXEC;
                        OP_BEQ:       state_d = S_BRANCH;
                        OP_J:         state_d = S_JUMP;
                        OP_ADDI:      state_d = S_ADDIEX;
                        default:      state_d = S_FETCH;
                    endcase
                end
            end
            S_MEMADR: state_d = (op == OP_LW) ? S_MEMRD : S_MEMWR;
            S_MEMRD:  state_d = mem_ready ? S_MEMWB : S_MEMRD;
            S_MEMWR:  state_d = mem_ready ? S_FETCH : S_MEMWR;
            S_EXEC:   state_d = S_RWB;
            S_ADDIEX: state_d = S_ADDIWB;
            S_MEMWB, S_RWB, S_BRANCH, S_JUMP, S_ADDIWB: state_d = S_FETCH;
            default:  state_d = S_FETCH;
        endcase
    end

    // Moore output decode; only FETCH gates its write enables with mem_ready
    always_comb begin
        ctrl = '0;
        case (state_q)
            S_FETCH: begin
                ctrl.mem_read  = 1'b1;
                ctrl.ir_write  = mem_ready;
                ctrl.alu_src_b = SRCB_FOUR;
                ctrl.pc_write  = mem_ready;
                ctrl.pc_source = PCSRC_ALU;
            end
            S_DECODE: begin
                ctrl.alu_src_b = SRCB_BOFS;
                ctrl.alu_op    = ALUOP_ADD;
            end
            S_MEMADR, S_ADDIEX: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_IMM;
                ctrl.alu_op    = ALUOP_ADD;
            end
            S_MEMRD: begin
                ctrl.mem_read = 1'b1;
                ctrl.iord     = 1'b1;
            end
            S_MEMWR: begin
                ctrl.mem_write = 1'b1;
                ctrl.iord      = 1'b1;
            end
            S_MEMWB: begin
                ctrl.reg_write  = 1'b1;
                ctrl.mem_to_reg = 1'b1;
            end
            S_EXEC: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_op    = ALUOP_FUNCT;
            end
            S_RWB: begin
                ctrl.reg_write = 1'b1;
                ctrl.reg_dst   = 1'b1;
            end
            S_BRANCH: begin
                ctrl.alu_src_a     = 1'b1;
                ctrl.alu_op        = ALUOP_SUB;
                ctrl.pc_write_cond = 1'b1;
                ctrl.pc_source     = PCSRC_ALUOUT;
            end
            S_JUMP: begin
                ctrl.pc_write  = 1'b1;
                ctrl.pc_source = PCSRC_JUMP;
            end
            S_ADDIWB: begin
                ctrl.reg_write = 1'b1;
            end
            default: ctrl = '0;
        endcase
    end

    assign PCWrite     = ctrl.pc_write;
    assign PCWriteCond = ctrl.pc_write_cond;
    assign PCSource    = ctrl.pc_source;
    assign IorD        = ctrl.iord;
    assign MemRead     = ctrl.mem_read;
    assign MemWrite    = ctrl.mem_write;
    assign IRWrite     = ctrl.ir_write;
    assign MemtoReg    = ctrl.mem_to_reg;
    assign RegDst      = ctrl.reg_dst;
    assign RegWrite    = ctrl.reg_write;
    assign ALUSrcA     = ctrl.alu_src_a;
    assign ALUSrcB     = ctrl.alu_src_b;
    assign ALUOp       = ctrl.alu_op;
    assign state       = state_q;
    assign ill_op      = ill_q;

endmodule

// File: tb/tb_ctrl_fsm.sv
// Scoreboard bench for ctrl_fsm: two instances (addi enabled / disabled)
// share stimulus; per-cycle expectations are queued and checked at negedge.
module tb_ctrl_fsm;
    import cpu_defs_pkg::*;

    logic       clk;
    logic       rst;
    logic [5:0] op;
    logic       mem_ready;

    logic       a_pcw, a_pcwc, a_iord, a_mr, a_mw, a_irw, a_m2r, a_rd, a_rw, a_sa, a_ill;
    logic [1:0] a_pcs, a_sb, a_aop;
    logic [3:0] a_st;
    logic       b_pcw, b_pcwc, b_iord, b_mr, b_mw, b_irw, b_m2r, b_rd, b_rw, b_sa, b_ill;
    logic [1:0] b_pcs, b_sb, b_aop;
    logic [3:0] b_st;

    ctrl_fsm #(.EN_ADDI(1'b1)) dut_a (
        .clk(clk), .rst(rst), .op(op), .mem_ready(mem_ready),
        .PCWrite(a_pcw), .PCWriteCond(a_pcwc), .PCSource(a_pcs), .IorD(a_iord),
        .MemRead(a_mr), .MemWrite(a_mw), .IRWrite(a_irw), .MemtoReg(a_m2r),
        .RegDst(a_rd), .RegWrite(a_rw), .ALUSrcA(a_sa), .ALUSrcB(a_sb),
        .ALUOp(a_aop), .state(a_st), .ill_op(a_ill)
    );

    ctrl_fsm #(.EN_ADDI(1'b0)) dut_b (
        .clk(clk), .rst(rst), .op(op), .mem_ready(mem_ready),
        .PCWrite(b_pcw), .PCWriteCond(b_pcwc), .PCSource(b_pcs), .IorD(b_iord),
        .MemRead(b_mr), .MemWrite(b_mw), .IRWrite(b_irw), .MemtoReg(b_m2r),
        .RegDst(b_rd), .RegWrite(b_rw), .ALUSrcA(b_sa), .ALUSrcB(b_sb),
        .ALUOp(b_aop), .state(b_st), .ill_op(b_ill)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // {state[3:0], ill_op, PCWrite, PCWriteCond, PCSource[1:0], IorD, MemRead,
    //  MemWrite, IRWrite, MemtoReg, RegDst, RegWrite, ALUSrcA, ALUSrcB[1:0], ALUOp[1:0]}
    logic [20:0] q_a[$];
    logic [20:0] q_b[$];
    logic        ill_a, ill_b;
    int          total = 0;
    int          bad   = 0;
    int          ncyc  = 0;

    // Hand table of outputs per state: order PCW PCWC PCS IorD MR MW IRW M2R RD RW SA SB AOP
    function automatic logic [15:0] exp_ctrl(input logic [3:0] s, input logic mr);
        logic [15:0] c;
        case (s)
            S_FETCH:  c = {mr,   1'b0, 2'b00, 1'b0, 1'b1, 1'b0, mr,   1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 2'b00};
            S_DECODE: c = 16'b0000_0000_0000_1100;
            S_MEMADR: c = 16'b0000_0000_0001_1000;
            S_MEMRD:  c = 16'b0000_1100_0000_0000;
            S_MEMWB:  c = 16'b0000_0000_1010_0000;
            S_MEMWR:  c = 16'b0000_1010_0000_0000;
            S_EXEC:   c = 16'b0000_0000_0001_0010;
            S_RWB:    c = 16'b0000_0000_0110_0000;
            S_BRANCH: c = 16'b0101_0000_0001_0001;
            S_JUMP:   c = 16'b1010_0000_0000_0000;
            S_ADDIEX: c = 16'b0000_0000_0001_1000;
            S_ADDIWB: c = 16'b0000_0000_0010_0000;
            default:  c = 16'h0000;
        endcase
        return c;
    endfunction

    // One cycle of stimulus with the expected state of each instance during it
    task automatic cyc(input logic [3:0] sa, input logic [3:0] sb,
                       input logic mr, input logic [5:0] o);
        op        = o;
        mem_ready = mr;
        q_a.push_back({sa, ill_a, exp_ctrl(sa, mr)});
        q_b.push_back({sb, ill_b, exp_ctrl(sb, mr)});
        @(posedge clk);
        #1;
    endtask

    // Monitor: one expectation per instance checked at each falling edge
    initial begin : monitor
        logic [20:0] exp_v, act_v;
        forever begin
            @(negedge clk);
            if (q_a.size() > 0) begin
                exp_v = q_a.pop_front();
                act_v = {a_st, a_ill, a_pcw, a_pcwc, a_pcs, a_iord, a_mr, a_mw, a_irw,
                         a_m2r, a_rd, a_rw, a_sa, a_sb, a_aop};
                total++;
                if (act_v !== exp_v) begin
                    bad++;
                    $display("FAIL addi_on cyc%0d: got %b required %b", ncyc, act_v, exp_v);
                end
            end
            if (q_b.size() > 0) begin
                exp_v = q_b.pop_front();
                act_v = {b_st, b_ill, b_pcw, b_pcwc, b_pcs, b_iord, b_mr, b_mw, b_irw,
                         b_m2r, b_rd, b_rw, b_sa, b_sb, b_aop};
                total++;
                if (act_v !== exp_v) begin
                    bad++;
                    $display("FAIL addi_off cyc%0d: got %b required %b", ncyc, act_v, exp_v);
                end
            end
            ncyc++;
        end
    end

    initial begin : stimulus
        rst       = 1'b0;
        op        = OP_R;
        mem_ready = 1'b1;
        ill_a     = 1'b0;
        ill_b     = 1'b0;
        @(posedge clk);
        #1;
        // held in reset
        cyc(S_FETCH, S_FETCH, 1'b1, OP_R);
        rst = 1'b1;

        // lw: 0,1,2,3,4
        cyc(S_FETCH,  S_FETCH,  1'b1, OP_LW);
        cyc(S_DECODE, S_DECODE, 1'b1, OP_LW);
        cyc(S_MEMADR, S_MEMADR, 1'b1, OP_LW);
        cyc(S_MEMRD,  S_MEMRD,  1'b1, OP_LW);
        cyc(S_MEMWB,  S_MEMWB,  1'b1, OP_LW);

        // sw with a fetch stall and three stalled MEMWR cycles
        cyc(S_FETCH,  S_FETCH,  1'b0, OP_SW);
        cyc(S_FETCH,  S_FETCH,  1'b1, OP_SW);
        cyc(S_DECODE, S_DECODE, 1'b1, OP_SW);
        cyc(S_MEMADR, S_MEMADR, 1'b1, OP_SW);
        cyc(S_MEMWR,  S_MEMWR,  1'b0, OP_SW);
        cyc(S_MEMWR,  S_MEMWR,  1'b0, OP_SW);
        cyc(S_MEMWR,  S_MEMWR,  1'b0, OP_SW);
        cyc(S_MEMWR,  S_MEMWR,  1'b1, OP_SW);

        // beq then j
        cyc(S_FETCH,  S_FETCH,  1'b1, OP_BEQ);
        cyc(S_DECODE, S_DECODE, 1'b1, OP_BEQ);
        cyc(S_BRANCH, S_BRANCH, 1'b1, OP_BEQ);
        cyc(S_FETCH,  S_FETCH,  1'b1, OP_J);
        cyc(S_DECODE, S_DECODE, 1'b1, OP_J);
        cyc(S_JUMP,   S_JUMP,   1'b1, OP_J);

        // addi: executes on instance a, illegal on instance b
        cyc(S_FETCH,  S_FETCH,  1'b1, OP_ADDI);
        cyc(S_DECODE, S_DECODE, 1'b1, OP_ADDI);
        ill_b = 1'b1;
        cyc(S_ADDIEX, S_FETCH,  1'b1, OP_ADDI);
        cyc(S_ADDIWB, S_DECODE, 1'b1, OP_ADDI);

        // illegal opcode, then an R-type with the flag held
        cyc(S_FETCH,  S_FETCH,  1'b1, 6'b111111);
        cyc(S_DECODE, S_DECODE, 1'b1, 6'b111111);
        ill_a = 1'b1;
        cyc(S_FETCH,  S_FETCH,  1'b1, OP_R);
        cyc(S_DECODE, S_DECODE, 1'b1, OP_R);
        cyc(S_EXEC,   S_EXEC,   1'b1, OP_R);
        cyc(S_RWB,    S_RWB,    1'b1, OP_R);

        // R-type aborted by reset between edges while in EXEC
        cyc(S_FETCH,  S_FETCH,  1'b1, OP_R);
        cyc(S_DECODE, S_DECODE, 1'b1, OP_R);
        #1;
        rst   = 1'b0;
        ill_a = 1'b0;
        ill_b = 1'b0;
        cyc(S_FETCH, S_FETCH, 1'b1, OP_R);
        cyc(S_FETCH, S_FETCH, 1'b1, OP_R);
        rst = 1'b1;

        // lw after reset, then back to FETCH
        cyc(S_FETCH,  S_FETCH,  1'b1, OP_LW);
        cyc(S_DECODE, S_DECODE, 1'b1, OP_LW);
        cyc(S_MEMADR, S_MEMADR, 1'b1, OP_LW);
        cyc(S_MEMRD,  S_MEMRD,  1'b1, OP_LW);
        cyc(S_MEMWB,  S_MEMWB,  1'b1, OP_LW);
        cyc(S_FETCH,  S_FETCH,  1'b1, OP_R);

        // bounded drain of the scoreboard
        for (int i = 0; i < 4; i++) begin
            if (q_a.size() != 0 || q_b.size() != 0) @(posedge clk);
        end
        total++;
        if (q_a.size() != 0 || q_b.size() != 0) begin
            bad++;
            $display("FAIL drain: got %0d/%0d pending required 0/0", q_a.size(), q_b.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
